// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs register fields, opcode/funct and a full
// 32-bit immediate into an instruction word, presented over a valid/ready
// stream with an auto-incrementing write address.
// Optional macro INSTR_ENCODER_RANGE_CHECK_EN enables sticky immediate range
// checking on imm_error; when undefined imm_error is tied low.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  format,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic [31:0] out_addr,
  output logic [15:0] word_count,
  output logic        imm_error
);

  localparam logic [2:0]  FMT_R = 3'd0;
  localparam logic [2:0]  FMT_I = 3'd1;
  localparam logic [2:0]  FMT_S = 3'd2;
  localparam logic [2:0]  FMT_B = 3'd3;
  localparam logic [2:0]  FMT_U = 3'd4;
  localparam logic [2:0]  FMT_J = 3'd5;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic        in_acc;
  logic        out_acc;
  logic [31:0] enc_word;

  // Clear blocks acceptance for its cycle; otherwise the stage accepts when empty or draining.
  assign in_ready = !clear && (!out_valid || out_ready);
  assign in_acc   = in_valid && in_ready;
  assign out_acc  = out_valid && out_ready;

  // Field packing per instruction format; reserved formats emit a nop.
  always_comb begin
    enc_word = NOP;
    case (format)
      FMT_R: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: enc_word = {imm[31:12], rd, opcode};
      FMT_J: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: enc_word = NOP;
    endcase
  end

  // Output stage, address and accepted-word counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      instr      <= 32'h0;
      out_addr   <= BASE_ADDR;
      word_count <= '0;
    end else if (clear) begin
      out_valid  <= 1'b0;
      out_addr   <= BASE_ADDR;
      word_count <= '0;
    end else begin
      if (out_acc) begin
        out_addr <= out_addr + 32'(ADDR_STEP);
        if (word_count != CNT_MAX) begin
          word_count <= word_count + CNT_W'(1);
        end
      end
      if (in_acc) begin
        instr     <= enc_word;
        out_valid <= 1'b1;
      end else if (out_acc) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  logic imm_bad;

  // Immediate does not fit the selected format (or format is reserved).
  always_comb begin
    imm_bad = 1'b0;
    case (format)
      FMT_R: imm_bad = 1'b0;
      FMT_I, FMT_S: imm_bad = !((&imm[31:11]) || !(|imm[31:11]));
      FMT_B: imm_bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      FMT_J: imm_bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      FMT_U: imm_bad = |imm[11:0];
      default: imm_bad = 1'b1;
    endcase
  end

  // Sticky error flag, cleared only by reset or clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      imm_error <= 1'b0;
    end else if (clear) begin
      imm_error <= 1'b0;
    end else if (in_acc && imm_bad) begin
      imm_error <= 1'b1;
    end
  end
`else
  assign imm_error = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors from the RV32I
// encodings plus randomized streaming against a queue-based reference model.
`timescale 1ns/1ps
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  format;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [31:0] out_addr;
  logic [15:0] word_count;
  logic        imm_error;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [31:0] exp_q[$];
  bit [31:0] m_addr;
  int        m_count;
  bit        m_err;

  instr_encoder dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .format(format), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .out_addr(out_addr),
    .word_count(word_count), .imm_error(imm_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit [31:0] bits(input bit [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'h1 << (hi - lo + 1)) - 32'h1);
  endfunction

  // Encoding computed by shifting each field to its bit position.
  function automatic bit [31:0] ref_enc(input int fmt, input bit [31:0] op, input bit [31:0] d,
                                         input bit [31:0] s1, input bit [31:0] s2,
                                         input bit [31:0] f3, input bit [31:0] f7,
                                         input bit [31:0] im);
    case (fmt)
      0: return op | (d << 7) | (f3 << 12) | (s1 << 15) | (s2 << 20) | (f7 << 25);
      1: return op | (d << 7) | (f3 << 12) | (s1 << 15) | (bits(im, 11, 0) << 20);
      2: return op | (bits(im, 4, 0) << 7) | (f3 << 12) | (s1 << 15) | (s2 << 20)
                | (bits(im, 11, 5) << 25);
      3: return op | (bits(im, 11, 11) << 7) | (bits(im, 4, 1) << 8) | (f3 << 12)
                | (s1 << 15) | (s2 << 20) | (bits(im, 10, 5) << 25) | (bits(im, 12, 12) << 31);
      4: return op | (d << 7) | (im & 32'hFFFF_F000);
      5: return op | (d << 7) | (bits(im, 19, 12) << 12) | (bits(im, 11, 11) << 20)
                | (bits(im, 10, 1) << 21) | (bits(im, 20, 20) << 31);
      default: return 32'h0000_0013;
    endcase
  endfunction

  // Range violation expressed as signed-value intervals and alignment.
  function automatic bit ref_viol(input int fmt, input bit [31:0] im);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    longint s;
    s = longint'($signed(im));
    case (fmt)
      0: return 1'b0;
      1, 2: return (s < -64'sd2048) || (s > 64'sd2047);
      3: return (s < -64'sd4096) || (s > 64'sd4095) || (im % 2 != 0);
      4: return (im % 4096) != 0;
      5: return (s < -64'sd1048576) || (s > 64'sd1048575) || (im % 2 != 0);
      default: return 1'b1;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_addr  = BASE;
    m_count = 0;
    m_err   = 1'b0;
  endtask

  // One clock: check presented state, predict handshakes, advance, check result.
  task automatic cycle();
    bit in_acc, out_acc, viol, mv, rdy;
    bit [31:0] e;
    #1;
    mv  = exp_q.size() > 0;
    rdy = !clear && (!mv || out_ready);
    check("in_ready", 32'(in_ready), 32'(rdy));
    if (mv) begin
      check("instr", instr, exp_q[0]);
      check("out_addr", out_addr, m_addr);
    end
    in_acc  = reset_n && in_valid && rdy;
    out_acc = reset_n && !clear && mv && out_ready;
    e    = ref_enc(int'(format), 32'(opcode), 32'(rd), 32'(rs1), 32'(rs2),
                   32'(funct3), 32'(funct7), imm);
    viol = ref_viol(int'(format), imm);
    @(posedge clk);
    if (!reset_n || clear) begin
      model_reset();
    end else begin
      if (out_acc) begin
        void'(exp_q.pop_front());
        m_addr += 32'd4;
        if (m_count < 65535) m_count++;
      end
      if (in_acc) begin
        exp_q.push_back(e);
        if (viol) m_err = 1'b1;
      end
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    check("word_count", 32'(word_count), 32'(m_count));
    check("imm_error", 32'(imm_error), 32'(m_err));
    check("addr_post", out_addr, m_addr);
  endtask

  task automatic put(input int fmt, input int op, input int d, input int s1, input int s2,
                     input int f3, input int f7, input bit [31:0] im);
    in_valid = 1'b1;
    format   = 3'(fmt);
    opcode   = 7'(op);
    rd       = 5'(d);
    rs1      = 5'(s1);
    rs2      = 5'(s2);
    funct3   = 3'(f3);
    funct7   = 7'(f7);
    imm      = im;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    clear    = 1'b0;
    cycle();
    reset_n  = 1'b1;
  endtask

  initial begin
    int v;
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 32'h0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_word_count", 32'(word_count), 32'h0);
    check("rst_imm_error", 32'(imm_error), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);

    // R-format add x3,x1,x2
    out_ready = 1'b1;
    put(0, 7'b0110011, 3, 1, 2, 0, 0, 32'h0);
    cycle();
    check("r_add", instr, 32'h002081B3);
    check("r_addr", out_addr, BASE);
    in_valid = 1'b0;
    cycle();
    check("r_in_ready", 32'(in_ready), 32'h1);

    // addi then sw streamed
    do_reset();
    out_ready = 1'b1;
    put(1, 7'b0010011, 1, 0, 0, 0, 0, 32'd5);
    cycle();
    check("i_addi", instr, 32'h00500093);
    check("i_addr", out_addr, 32'h0);
    put(2, 7'b0100011, 0, 1, 2, 3'b010, 0, 32'd8);
    cycle();
    check("s_sw", instr, 32'h0020A423);
    check("s_addr", out_addr, 32'h4);
    in_valid = 1'b0;
    cycle();
    check("is_count", 32'(word_count), 32'd2);

    // U / J / B
    put(4, 7'b0110111, 5, 0, 0, 0, 0, 32'h12345000);
    cycle();
    check("u_lui", instr, 32'h123452B7);
    put(5, 7'b1101111, 1, 0, 0, 0, 0, 32'd8);
    cycle();
    check("j_jal", instr, 32'h008000EF);
    put(3, 7'b1100011, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
    cycle();
    check("b_beq", instr, 32'hFE000EE3);
    in_valid = 1'b0;
    cycle();

    // Backpressure: two words, stall 3 cycles, then drain in order
    do_reset();
    out_ready = 1'b0;
    put(1, 7'b0010011, 1, 0, 0, 0, 0, 32'd1);
    cycle();
    put(1, 7'b0010011, 2, 0, 0, 0, 0, 32'd2);
    repeat (3) begin
      cycle();
      check("bp_in_ready", 32'(in_ready), 32'h0);
      check("bp_instr", instr, 32'h00100093);
      check("bp_addr", out_addr, 32'h0);
    end
    out_ready = 1'b1;
    cycle();
    check("bp_second", instr, 32'h00200113);
    check("bp_second_addr", out_addr, 32'h4);
    in_valid = 1'b0;
    cycle();
    check("bp_count", 32'(word_count), 32'd2);

    // Range check and clear
    put(1, 7'b0010011, 1, 0, 0, 0, 0, 32'd2048);
    cycle();
    check("rc_field", 32'(instr[31:20]), 32'h800);
    in_valid = 1'b0;
    cycle();
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    check("rc_sticky", 32'(imm_error), 32'h1);
`else
    check("rc_tied", 32'(imm_error), 32'h0);
`endif
    clear = 1'b1;
    put(0, 7'b0110011, 1, 1, 1, 0, 0, 32'h0);
    cycle();
    clear = 1'b0;
    in_valid = 1'b0;
    check("clr_err", 32'(imm_error), 32'h0);
    check("clr_addr", out_addr, BASE);
    check("clr_count", 32'(word_count), 32'h0);
    check("clr_valid", 32'(out_valid), 32'h0);

    // Reset mid-stall
    out_ready = 1'b0;
    put(0, 7'b0110011, 4, 5, 6, 0, 0, 32'h0);
    cycle();
    in_valid = 1'b0;
    cycle();
    do_reset();
    check("rms_valid", 32'(out_valid), 32'h0);
    check("rms_addr", out_addr, BASE);
    check("rms_count", 32'(word_count), 32'h0);

    // Randomized streaming
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: v = int'($urandom_range(0, 8191)) - 4096;
        1: v = int'($urandom_range(0, 4095)) - 2048;
        2: v = int'($urandom & 32'hFFFF_F000);
        default: v = int'($urandom);
      endcase
      put(int'($urandom_range(0, 7)), int'($urandom_range(0, 127)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 127)), 32'(v));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 39) == 0);
      reset_n   = ($urandom_range(0, 99) != 0);
      cycle();
    end
    reset_n = 1'b1;
    clear   = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
